// File: rtl/uart_pkg.sv
// Shared definitions for the UART configuration path (transmit side today,
// loopback receive checker later).
package uart_pkg;

    localparam int DATA_BITS                 = 8;
    localparam int CLKS_PER_BIT_115200_50MHZ = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from
// the count so no input ever reaches the status outputs combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_bitstream_tx.sv
// 8N1 UART transmitter feeding configuration bytes onto the eFPGA Rx line;
// buffered input, back-to-back frames, fixed baud divider.
module uart_bitstream_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_50MHZ,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic [DATA_BITS-1:0]        data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        Tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    uart_tx_state_t       state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 tx_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 bit_end;
    logic                 pop;

    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // Pop on the same edge that starts a frame, so a stop bit runs straight into the next start bit.
    assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (resetn),
        .push    (data_valid),
        .wr_data (data_in),
        .pop     (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift    <= fifo_data;
                        baud_cnt <= '0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Drive the next bit directly from shift[1] so Tx stays a plain flop.
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift <= fifo_data;
                            tx_q  <= 1'b0;
                            state <= START;
                        end else begin
                            tx_q  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Tx         = tx_q;
    assign data_ready = !fifo_full;
    assign busy       = (state != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_bitstream_tx.sv
// Directed bench for uart_bitstream_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4 and a
// mid-bit sampling receiver model that decodes every completed frame.
module tb_uart_bitstream_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   track   = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    uart_bitstream_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .Tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, acc = that edge number.
    task automatic send(input logic [7:0] b, output int acc);
        logic rdy;
        int   budget;
        budget     = 200;
        acc        = -1;
        data_in    = b;
        data_valid = 1'b1;
        while (acc < 0 && budget > 0) begin
            rdy = data_ready;
            @(negedge clk);
            if (rdy) acc = cyc;
            budget--;
        end
        data_valid = 1'b0;
        check("send_accepted", acc >= 0, 1);
        if (acc >= 0 && track) exp_q.push_back(b);
    endtask

    // Checks Tx on every cycle of one frame, starting at the current negedge.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CPB; j++) begin
                check(tag, tx, bits[i]);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", busy, 0);
        check("drain_level", fifo_level, 0);
    endtask

    // Receiver model: frame start seen at a negedge, samples taken at mid-bit.
    initial begin : rx_model
        logic [7:0] d;
        bit         ok;
        forever begin
            @(negedge clk);
            if (resetn && tx === 1'b0) begin
                d  = 8'h00;
                ok = 1'b1;
                for (int c = 1; c < 10 * CPB; c++) begin
                    @(negedge clk);
                    if (!resetn) begin
                        ok = 1'b0;
                        break;
                    end
                    if (c % CPB == CPB / 2) begin
                        if (c / CPB == 0) check("rx_start", tx, 0);
                        else if (c / CPB <= 8) d[c / CPB - 1] = tx;
                        else check("rx_stop", tx, 1);
                    end
                end
                if (ok) rx_q.push_back(d);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        int kx;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", data_ready, 1);
        check("rst_level", fifo_level, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Single byte 0xA5
        send(8'hA5, k);
        check("a5_level_after_push", fifo_level, 1);
        check("a5_tx_before_start", tx, 1);
        @(negedge clk);
        check("a5_level_after_pop", fifo_level, 0);
        check("a5_busy_in_frame", busy, 1);
        expect_frame(8'hA5, "a5_line");
        check("a5_busy_end", busy, 0);
        check("a5_tx_idle", tx, 1);

        // Back-to-back 0x00, 0xFF
        send(8'h00, k);
        send(8'hFF, kx);
        check("b2b_consecutive", kx - k, 1);
        check("b2b_level_push_pop", fifo_level, 1);
        expect_frame(8'h00, "b2b_first");
        expect_frame(8'hFF, "b2b_second");
        check("b2b_busy_end", busy, 0);

        // Full FIFO with 0x01..0x06
        send(8'h01, k);
        for (int b = 2; b <= 5; b++) send(8'(b), kx);
        check("full_level", fifo_level, 4);
        check("full_ready_low", data_ready, 0);
        send(8'h06, kx);
        check("full_held_until_pop", kx - k, 42);
        check("full_level_refill", fifo_level, 4);
        wait_idle(400);

        // Simultaneous push and pop at level 2
        send(8'h5A, k);
        send(8'hC3, kx);
        send(8'h0F, kx);
        check("sim_level_before", fifo_level, 2);
        while (cyc < k + 40) @(negedge clk);
        check("sim_level_at_stop_end", fifo_level, 2);
        check("sim_ready", data_ready, 1);
        data_in    = 8'h96;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        exp_q.push_back(8'h96);
        check("sim_level_after", fifo_level, 2);
        check("sim_next_start", tx, 0);
        wait_idle(400);

        // Reset during DATA bit 3 of 0x3C with two bytes queued
        track = 1'b0;
        send(8'h3C, k);
        send(8'h11, kx);
        send(8'h22, kx);
        track = 1'b1;
        while (cyc < k + 18) @(negedge clk);
        check("rst_mid_level_pre", fifo_level, 2);
        check("rst_mid_busy_pre", busy, 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_ready", data_ready, 1);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_release_tx", tx, 1);
        check("rst_release_busy", busy, 0);
        send(8'h81, k);
        @(negedge clk);
        expect_frame(8'h81, "rst_clean_frame");
        check("rst_busy_end", busy, 0);
        repeat (4) @(negedge clk);

        // Decoded line against pushed bytes
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("rx_byte_%0d", i), rx_q[i], exp_q[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
